mdu_seq: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the multicycle datapath.
- Produces the HI/LO result words consumed by the ALU result register on the done cycle.
- Accepts operands from the A/B operand registers on a start pulse and runs a fixed-latency shift-add (multiply) or restoring shift-subtract (divide) sequence.
- Handshake toward the controller FSM: start / busy / done.

---
 rtl/mdu_seq.sv | 88 ++++++++
 tb/tb_mdu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32-cycle shift-add multiply / restoring divide unit with start/busy/done handshake.
// Ports: clk, reset (async active-low); start/op/a/b request (sampled in IDLE);
//        busy while running; done one-cycle pulse; hi/lo result words; div_by_zero flag.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] op_r;
  logic neg_q, neg_r;
  // d is the multiplicand (multiply) or divisor (divide); w_lo starts as multiplier or dividend
  logic [WIDTH-1:0] d, w_hi, w_lo, mag_a, mag_b;
  logic [WIDTH:0] mul_sum, shifted;
  logic [WIDTH-1:0] diff, div_hi, q_f, r_f;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic ge, dz;
  assign busy = state != IDLE;
  assign mag_a = (op[0] & a[WIDTH-1]) ? -a : a;
  assign mag_b = (op[0] & b[WIDTH-1]) ? -b : b;
  assign mul_sum = {1'b0, w_hi} + {1'b0, w_lo[0] ? d : '0};
  assign shifted = {w_hi, w_lo[WIDTH-1]};
  assign ge = shifted >= {1'b0, d};
  // remainder after a successful subtract is below d, so the low WIDTH bits are exact
  assign diff = shifted[WIDTH-1:0] - d;
  assign div_hi = ge ? diff : shifted[WIDTH-1:0];
  assign prod = {w_hi, w_lo};
  assign prod_f = neg_q ? -prod : prod;
  assign dz = op_r[1] && d == '0;
  // with d==0 every subtract succeeds: quotient is all ones, remainder is |a|, so only the quotient fixup is suppressed
  assign q_f = dz ? '1 : neg_q ? -w_lo : w_lo;
  assign r_f = neg_r ? -w_hi : w_hi;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN) ? (cnt == '0 ? FIXUP : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      op_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      d <= '0;
      w_hi <= '0;
      w_lo <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= state == FIXUP;
      if (state == IDLE && start) begin
        op_r <= op;
        neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= op[0] & a[WIDTH-1];
        d <= op[1] ? mag_b : mag_a;
        w_hi <= '0;
        w_lo <= op[1] ? mag_a : mag_b;
        cnt <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
        w_hi <= op_r[1] ? div_hi : mul_sum[WIDTH:1];
        w_lo <= op_r[1] ? {w_lo[WIDTH-2:0], ge} : {mul_sum[0], w_lo[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
      end else if (state == FIXUP) begin
        hi <= op_r[1] ? r_f : prod_f[2*WIDTH-1:WIDTH];
        lo <= op_r[1] ? q_f : prod_f[WIDTH-1:0];
        div_by_zero <= dz;
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq with directed corner cases and randomized operations.
module tb_mdu_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz;} res_t;
  res_t sbq[$];
  int checks = 0, errors = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    longint sx, sy;
    logic [63:0] p;
    r.dbz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 0) begin
      r.lo = '1;
      r.hi = x;
      r.dbz = 1'b1;
    end else if (o == 2'd0) begin
      p = {32'b0, x} * {32'b0, y};
      {r.hi, r.lo} = p;
    end else if (o == 2'd1) begin
      p = sx * sy;
      {r.hi, r.lo} = p;
    end else if (o == 2'd2) begin
      r.lo = x / y;
      r.hi = x % y;
    end else begin
      p = sx / sy;
      r.lo = p[31:0];
      p = sx % sy;
      r.hi = p[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && done) begin
      res_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 expected=0");
      end else begin
        e = sbq.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_dbz", div_by_zero, e.dbz);
      end
    end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) sbq.push_back(model(o, x, y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", busy, 1);
      n = i;
      if (done) break;
    end
    chk("latency", n, 33);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic run_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez);
    issue(o, x, y, 1);
    wait_done();
    chk("tp_hi", hi, eh);
    chk("tp_lo", lo, el);
    chk("tp_dbz", div_by_zero, ez);
  endtask

  initial begin
    logic [1:0] ro;
    logic [31:0] ra, rb;
    #12;
    chk("rst_outs", {busy, done, div_by_zero, hi, lo}, 0);
    @(negedge clk) reset = 1'b1;
    run_exp(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_exp(2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_exp(2'd0, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 0);
    run_exp(2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_exp(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_exp(2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run_exp(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
    run_exp(2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 0);
    run_exp(2'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
    // start while busy is ignored; start in the done cycle is accepted
    issue(2'd2, 32'd9, 32'd3, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("ign_done", done, 1);
    chk("ign_lo", lo, 3);
    chk("ign_hi", hi, 0);
    start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
    sbq.push_back(model(2'd0, 32'd2, 32'd2));
    @(posedge clk);
    #1 start = 1'b0;
    chk("bb_busy", busy, 1);
    chk("bb_hold", {hi, lo}, {32'd0, 32'd3});
    wait_done();
    chk("bb_lo", lo, 4);
    // asynchronous reset mid-operation
    issue(2'd0, 32'h1234, 32'h10, 0);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("arst_outs", {busy, done, div_by_zero, hi, lo}, 0);
    repeat (40) @(negedge clk) if (done) chk("arst_nodone", done, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk) if (done) chk("arst_nodone2", done, 0);
    run_exp(2'd2, 32'd10, 32'd3, 32'd1, 32'd3, 0);
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      issue(ro, ra, rb, 1);
      wait_done();
    end
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
